// File: rtl/enemy_ai_core.sv
//==============================================================================
// enemy_ai_core : lane-hopping opponent with telegraphed wind-up/strike cycle.
// Optional ENEMY_RANDOM_LANE_EN selects LFSR-driven lane choice.  Rev 1.0
//==============================================================================
`default_nettype none

module enemy_ai_core #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int NUM_LANES     = 3,
  parameter int LANE_X0       = 20,
  parameter int LANE_SPACING  = 40,
  parameter int Y_POS         = 8,
  parameter int MOVES_SLOW    = 4,
  parameter int MOVES_FAST    = 2,
  parameter int WINDUP_STEPS  = 2,
  parameter int RECOVER_STEPS = 2,
  parameter int STUN_STEPS    = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       aggression,
  input  logic       hit,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] lane,
  output logic       move,
  output logic       windup,
  output logic       punch,
  output logic       stunned,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_WINDUP  = 3'd2,
    S_STRIKE  = 3'd3,
    S_RECOVER = 3'd4,
    S_STUN    = 3'd5
  } state_t;

  localparam int            TW          = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_LANE   = 3'(NUM_LANES - 1);

  state_t        state_q, state_d;
  logic [2:0]    lane_q, lane_d;
  logic [7:0]    x_q, x_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    step_q, step_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          move_q, move_d;
  logic          windup_q, windup_d;
  logic          punch_q, punch_d;
  logic          stunned_q, stunned_d;

  logic [1:0]    period_m1_w;
  logic          tick_w;
  logic          step_w;
  logic [2:0]    wrap_lane_w;
  logic [2:0]    next_lane_w;
  logic [7:0]    cnt_inc_w;
  logic [7:0]    move_thr_w;

`ifdef ENEMY_RANDOM_LANE_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] rnd_lane_w;

  always_comb begin
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rnd_lane_w = 3'(lfsr_q % 8'(NUM_LANES));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    case (speed)
      2'd0:    period_m1_w = 2'd3;
      2'd1:    period_m1_w = 2'd1;
      default: period_m1_w = 2'd0;
    endcase
    tick_w      = (state_q != S_IDLE) && (tick_q == '0);
    // Using >= lets a speed-up mid-period fire on the very next tick.
    step_w      = tick_w && (step_q >= period_m1_w);
    wrap_lane_w = (lane_q == LAST_LANE) ? 3'd0 : 3'(lane_q + 3'd1);
`ifdef ENEMY_RANDOM_LANE_EN
    next_lane_w = (rnd_lane_w == lane_q) ? wrap_lane_w : rnd_lane_w;
`else
    next_lane_w = wrap_lane_w;
`endif
    cnt_inc_w   = 8'(cnt_q + 8'd1);
    move_thr_w  = aggression ? 8'(MOVES_FAST) : 8'(MOVES_SLOW);
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    move_d  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_MOVE;
        S_MOVE: begin
          if (step_w) begin
            lane_d = next_lane_w;
            move_d = 1'b1;
            cnt_d  = cnt_inc_w;
            if (cnt_inc_w >= move_thr_w) state_d = S_WINDUP;
          end
        end
        S_WINDUP: begin
          if (hit) state_d = S_STUN;
          else if (step_w) begin
            cnt_d = cnt_inc_w;
            if (cnt_inc_w >= 8'(WINDUP_STEPS)) state_d = S_STRIKE;
          end
        end
        S_STRIKE: state_d = S_RECOVER;
        S_RECOVER: begin
          if (hit) state_d = S_STUN;
          else if (step_w) begin
            cnt_d = cnt_inc_w;
            if (cnt_inc_w >= 8'(RECOVER_STEPS)) state_d = S_MOVE;
          end
        end
        S_STUN: begin
          if (step_w) begin
            cnt_d = cnt_inc_w;
            if (cnt_inc_w >= 8'(STUN_STEPS)) state_d = S_MOVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Every state change restarts the tick phase so each phase lasts whole ticks.
  always_comb begin
    tick_d = tick_q;
    step_d = step_q;
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      tick_d = TICK_RELOAD;
      step_d = 2'd0;
    end else if (tick_w) begin
      tick_d = TICK_RELOAD;
      step_d = step_w ? 2'd0 : 2'(step_q + 2'd1);
    end else begin
      tick_d = TW'(tick_q - 1'b1);
    end
  end

  always_comb begin
    x_d       = 8'(LANE_X0 + int'(lane_d) * LANE_SPACING);
    windup_d  = (state_d == S_WINDUP);
    punch_d   = (state_d == S_STRIKE);
    stunned_d = (state_d == S_STUN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      lane_q    <= 3'd0;
      x_q       <= 8'(LANE_X0);
      tick_q    <= TICK_RELOAD;
      step_q    <= 2'd0;
      cnt_q     <= 8'd0;
      move_q    <= 1'b0;
      windup_q  <= 1'b0;
      punch_q   <= 1'b0;
      stunned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      x_q       <= x_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      windup_q  <= windup_d;
      punch_q   <= punch_d;
      stunned_q <= stunned_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = 7'(Y_POS);
  assign lane    = lane_q;
  assign move    = move_q;
  assign windup  = windup_q;
  assign punch   = punch_q;
  assign stunned = stunned_q;
  assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_ai_core.sv
//==============================================================================
// tb_enemy_ai_core : scoreboard bench; expected output events are queued by the
// stimulus and popped by a monitor whenever the enemy changes state or pulses.
//==============================================================================
`default_nettype none

module tb_enemy_ai_core;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] speed = 2'd2;
  logic       aggression = 1'b1;
  logic       hit = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] lane;
  logic       move, windup, punch, stunned;
  logic [2:0] state;

  enemy_ai_core #(.TICK_DIV(4)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .speed(speed),
    .aggression(aggression), .hit(hit), .x_out(x_out), .y_out(y_out),
    .lane(lane), .move(move), .windup(windup), .punch(punch),
    .stunned(stunned), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         gap;   // samples since previous event, -1 = don't care
    logic [2:0] st;
    logic [7:0] x;
    logic [3:0] fl;    // {move, windup, punch, stunned}
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   ev_idx = 0;
  int   rnd_moves = 0;
  int   cur = 0;
  bit   free_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int gap, input logic [2:0] st, input logic [7:0] x,
                      input logic [3:0] fl);
    exp_t e;
    e.gap = gap; e.st = st; e.x = x; e.fl = fl;
    sb_q.push_back(e);
  endtask

  // Park on the negedge just before edge k of the current timeline.
  task automatic to_edge(input int k);
    repeat (k - cur) @(negedge clock);
    cur = k;
  endtask

  // Monitor
  initial begin
    logic [2:0] prev_state;
    logic [2:0] prev_lane;
    int since;
    exp_t e;
    prev_state = 3'd0;
    prev_lane  = 3'd0;
    since      = 0;
    forever begin
      @(posedge clock);
      #1;
      since++;
      if (free_run) begin
        if (move) begin
          rnd_moves++;
          chk("rnd_range", 32'(lane < 3'd3), 32'd1);
          chk("rnd_change", 32'(lane != prev_lane), 32'd1);
        end
      end else if (move || punch || (state != prev_state)) begin
        ev_idx++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event%0d: state=%0d x=%0d flags=%b, expected no event",
                   ev_idx, state, x_out, {move, windup, punch, stunned});
        end else begin
          e = sb_q.pop_front();
          if (e.gap >= 0) chk($sformatf("ev%0d_gap", ev_idx), 32'(since), 32'(e.gap));
          chk($sformatf("ev%0d_state", ev_idx), 32'(state), 32'(e.st));
`ifndef ENEMY_RANDOM_LANE_EN
          chk($sformatf("ev%0d_x", ev_idx), 32'(x_out), 32'(e.x));
`endif
          chk($sformatf("ev%0d_flags", ev_idx), 32'({move, windup, punch, stunned}),
              32'(e.fl));
        end
        since = 0;
      end
      prev_state = state;
      prev_lane  = lane;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      chk("idle_after_reset", {state, x_out, y_out, lane, move, windup, punch, stunned},
          {3'd0, 8'd20, 7'd8, 3'd0, 4'b0000});
    end

    // Fast aggressive run: two moves, wind-up, strike, recover, two moves.
    @(negedge clock);
    cur = 1;
    push(-1, 3'd1, 8'd20,  4'b0000);
    push( 4, 3'd1, 8'd60,  4'b1000);
    push( 4, 3'd2, 8'd100, 4'b1100);
    push( 8, 3'd3, 8'd100, 4'b0010);
    push( 1, 3'd4, 8'd100, 4'b0000);
    push( 8, 3'd1, 8'd100, 4'b0000);
    push( 4, 3'd1, 8'd20,  4'b1000);
    push( 4, 3'd2, 8'd60,  4'b1100);
    enable = 1'b1;

    // Hit during wind-up, second hit during stun ignored.
    to_edge(36);
    push( 2, 3'd5, 8'd60,  4'b0001);
    push(12, 3'd1, 8'd60,  4'b0000);
    push( 4, 3'd1, 8'd100, 4'b1000);
    push( 4, 3'd2, 8'd20,  4'b1100);
    hit = 1'b1;
    to_edge(37);
    hit = 1'b0;
    to_edge(41);
    hit = 1'b1;
    to_edge(42);
    hit = 1'b0;

    // Disable mid wind-up, then re-enable with slow aggression.
    to_edge(58);
    push( 2, 3'd0, 8'd20,  4'b0000);
    enable = 1'b0;
    to_edge(62);
    push(-1, 3'd1, 8'd20,  4'b0000);
    push( 4, 3'd1, 8'd60,  4'b1000);
    enable = 1'b1;
    aggression = 1'b0;

    // Slow speed, then speed-up while step count is 2 fires immediately.
    to_edge(67);
    push(16, 3'd1, 8'd100, 4'b1000);
    speed = 2'd0;
    to_edge(92);
    push(12, 3'd1, 8'd20,  4'b1000);
    push( 8, 3'd2, 8'd60,  4'b1100);
    push(16, 3'd3, 8'd60,  4'b0010);
    push( 1, 3'd4, 8'd60,  4'b0000);
    speed = 2'd1;

    // Asynchronous reset between edges during RECOVER.
    to_edge(122);
    push(-1, 3'd0, 8'd20,  4'b0000);
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    chk("async_reset", {state, x_out, y_out, lane, move, windup, punch, stunned},
        {3'd0, 8'd20, 7'd8, 3'd0, 4'b0000});
    enable = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

`ifdef ENEMY_RANDOM_LANE_EN
    free_run = 1'b1;
    speed = 2'd2;
    aggression = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 4000 && rnd_moves < 100; c++) @(negedge clock);
    chk("rnd_move_count", 32'(rnd_moves >= 100), 32'd1);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    free_run = 1'b0;
`endif

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
